// File: rtl/seq_divider_32.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_32
// Description : Multi-cycle unsigned restoring divider, one quotient bit per
//               clock, with start/busy/done handshake and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0]       C_LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_ALL_ONES  = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] w_div_nxt;
    logic [5:0]       r_cnt;
    logic [5:0]       w_cnt_nxt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] w_quot_nxt;
    logic [WIDTH-1:0] r_remd;
    logic [WIDTH-1:0] w_remd_nxt;
    logic             r_dz;
    logic             w_dz_nxt;

    // Trial subtraction is one bit wider than the operands so the top bit of
    // the partial remainder survives the shift and the MSB of the result is
    // the borrow.
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_q_step;

    assign w_trial    = {r_rem, r_q[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_div};
    assign w_borrow   = w_diff[WIDTH];
    assign w_rem_step = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_q_step   = {r_q[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_q_nxt     = r_q;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_quot_nxt  = r_quot;
        w_remd_nxt  = r_remd;
        w_dz_nxt    = r_dz;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_div_nxt = divisor;
                    w_q_nxt   = dividend;
                    w_rem_nxt = '0;
                    w_cnt_nxt = '0;
                    if (divisor == '0) begin
                        w_state_nxt = ST_DONE;
                        w_quot_nxt  = C_ALL_ONES;
                        w_remd_nxt  = dividend;
                        w_dz_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_rem_nxt = w_rem_step;
                w_q_nxt   = w_q_step;
                w_cnt_nxt = r_cnt + 6'd1;
                // Final iteration lands straight in the result registers.
                if (r_cnt == C_LAST_ITER) begin
                    w_state_nxt = ST_DONE;
                    w_quot_nxt  = w_q_step;
                    w_remd_nxt  = w_rem_step;
                    w_dz_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_remd <= '0;
            r_dz   <= 1'b0;
        end else begin
            r_rem  <= w_rem_nxt;
            r_q    <= w_q_nxt;
            r_div  <= w_div_nxt;
            r_cnt  <= w_cnt_nxt;
            r_quot <= w_quot_nxt;
            r_remd <= w_remd_nxt;
            r_dz   <= w_dz_nxt;
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign quotient  = r_quot;
    assign remainder = r_remd;
    assign div_zero  = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider_32
// Description : Directed-vector scoreboard bench for seq_divider_32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider_32;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            check("done_busy_exclusive", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_zero", 32'(div_zero), 32'(e.dz));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] dvd, input logic [31:0] dvs);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs,
                            input logic [31:0] q, input logic [31:0] r, input logic dz);
        sb.push_back('{q: q, r: r, dz: dz});
        pulse_start(dvd, dvs);
    endtask

    // Counts edges from the current sample point until done, and busy samples on the way.
    task automatic wait_done(input string nm, input int exp_lat, input int exp_busy);
        int cyc;
        int bsy;
        cyc = 0;
        bsy = 0;
        while (!done && cyc < 100) begin
            if (busy) bsy++;
            tick();
            cyc++;
        end
        if (cyc >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in %0d cycles expected done", nm, cyc);
        end else begin
            check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
            check({nm, "_busy_cycles"}, 32'(bsy), 32'(exp_busy));
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done("div_100_7", 32, 32);
        tick();

        start_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        wait_done("div_max_1", 32, 32);
        tick();

        start_op(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
        wait_done("div_max_msb", 32, 32);
        tick();

        start_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        wait_done("div_by_zero", 0, 0);
        tick();
        check("dz_returns_idle_done", 32'(done), 32'd0);

        start_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        wait_done("div_9_3", 32, 32);
        tick();

        // Start pulse during RUN must be ignored; outputs hold the old result.
        start_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
        repeat (9) tick();
        pulse_start(32'd50, 32'd5);
        check("run_hold_quotient", quotient, 32'd3);
        check("run_hold_remainder", remainder, 32'd0);
        check("run_busy", 32'(busy), 32'd1);
        wait_done("div_3_10", 22, 22);
        tick();
        repeat (40) tick();
        check("ignored_start_quotient", quotient, 32'd0);
        check("ignored_start_remainder", remainder, 32'd3);

        // Asynchronous reset mid-run.
        pulse_start(32'd1000, 32'd3);
        repeat (14) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_div_zero", 32'(div_zero), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        start_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        wait_done("div_1000_3", 32, 32);
        tick();

        // Back-to-back with start held high.
        sb.push_back('{q: 32'd11, r: 32'd0, dz: 1'b0});
        sb.push_back('{q: 32'd11, r: 32'd1, dz: 1'b0});
        dividend = 32'd77;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        wait_done("b2b_first", 32, 32);
        dividend = 32'd78;
        tick();
        start = 1'b0;
        check("b2b_done_dropped", 32'(done), 32'd0);
        check("b2b_busy_rose", 32'(busy), 32'd1);
        check("b2b_hold_quotient", quotient, 32'd11);
        check("b2b_hold_remainder", remainder, 32'd0);
        wait_done("b2b_second", 32, 32);
        tick();

        repeat (5) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
